// File: rtl/rtp_rx_depacketizer_if.sv
// Byte-stream and playback handshake bundle for the RTP receive depacketizer.
// The UDP receive side feeds bytes in; the codec side requests samples out.
interface rtp_rx_depacketizer_if;
   logic        udp_rec_data_valid;
   logic [7:0]  udp_rec_rdata;
   logic [15:0] udp_rec_data_length;
   logic        wav_rden;
   logic [15:0] wav_out_data;
   logic        wav_out_valid;

   modport master (
      output udp_rec_data_valid,
      output udp_rec_rdata,
      output udp_rec_data_length,
      output wav_rden,
      input  wav_out_data,
      input  wav_out_valid
   );

   modport slave (
      input  udp_rec_data_valid,
      input  udp_rec_rdata,
      input  udp_rec_data_length,
      input  wav_rden,
      output wav_out_data,
      output wav_out_valid
   );
endinterface

// File: rtl/rtp_rx_depacketizer.sv
// RTP receive depacketizer: validates the 12-byte RTP header of each UDP
// payload, unpacks big-endian 16-bit PCM samples into a sample FIFO and
// plays them out one per codec request, with prefill/underrun handling and
// sequence-gap detection.
module rtp_rx_depacketizer #(
   parameter logic [7:0]  RTP_HDR_B0 = 8'h80,
   parameter logic [6:0]  PT         = 7'd0,
   parameter logic [31:0] SSRC       = 32'h12345678,
   parameter bit          CHECK_SSRC = 1'b1,
   parameter int          AW         = 10,
   parameter int          PREFILL    = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rtp_rx_depacketizer_if.slave  bus,
   output logic [AW:0]           fifo_level,
   output logic                  pkt_ok,
   output logic                  pkt_drop,
   output logic                  seq_gap,
   output logic [15:0]           last_seq,
   output logic                  overflow,
   output logic                  underrun
);

   localparam logic [AW:0] DEPTH_L   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] PREFILL_L = (AW+1)'(PREFILL);
   localparam logic [AW:0] ONE_L     = (AW+1)'(1);
   localparam logic [AW:0] ZERO_L    = '0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_DONE    = 3'd3,
      ST_DISCARD = 3'd4
   } state_t;

   // Parser state
   state_t        state_q;
   logic          prev_valid_q;
   logic [15:0]   cnt_q;
   logic [15:0]   len_q;
   logic [15:0]   seq_tmp_q;
   logic [23:0]   ssrc_q;
   logic [7:0]    hi_q;
   logic          have_seq_q;
   logic [15:0]   last_seq_q;
   logic          pkt_ok_q;
   logic          pkt_drop_q;
   logic          seq_gap_q;

   // Sample FIFO and playback state
   logic [15:0]   mem_q [DEPTH_L];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          primed_q;
   logic [15:0]   wav_out_data_q;
   logic          wav_out_valid_q;
   logic          overflow_q;
   logic          underrun_q;

   // Combinational helpers
   logic          valid_s;
   logic [7:0]    byte_s;
   logic          byte0_s;
   logic          len_bad_s;
   logic          ssrc_ok_s;
   logic          accept_s;
   logic [15:0]   seq_next_s;
   logic          fifo_wr_s;
   logic [15:0]   fifo_wdata_s;
   logic          full_s;
   logic          empty_s;
   logic          pop_s;
   logic          wr_ok_s;

   assign valid_s    = bus.udp_rec_data_valid;
   assign byte_s     = bus.udp_rec_rdata;
   assign seq_next_s = last_seq_q + 16'd1;

   // Packet-level decode: start-of-packet, header checks, acceptance and FIFO write/pop qualification
   always_comb begin
      byte0_s      = valid_s & ~prev_valid_q;
      // Payload length must be even; 12 is even so an odd total length means an odd payload.
      len_bad_s    = (bus.udp_rec_data_length < 16'd12) | bus.udp_rec_data_length[0];
      if (CHECK_SSRC) begin
         ssrc_ok_s = ({ssrc_q, byte_s} == SSRC);
      end else begin
         ssrc_ok_s = 1'b1;
      end
      accept_s     = 1'b0;
      if (valid_s && (state_q == ST_HDR) && (cnt_q == 16'd11)) begin
         accept_s = ssrc_ok_s & (len_q == 16'd12);
      end else if (valid_s && (state_q == ST_PAYLOAD)) begin
         accept_s = (cnt_q == (len_q - 16'd1));
      end else begin
         accept_s = 1'b0;
      end
      // Header is 12 bytes (even), so odd byte indices close a sample.
      fifo_wr_s    = valid_s & (state_q == ST_PAYLOAD) & cnt_q[0];
      fifo_wdata_s = {hi_q, byte_s};
      full_s       = (level_q == DEPTH_L);
      empty_s      = (level_q == ZERO_L);
      pop_s        = bus.wav_rden & primed_q & ~empty_s;
      // The pop frees a slot before the write is judged, so full+pop+write succeeds.
      wr_ok_s      = fifo_wr_s & (~full_s | pop_s);
   end

   // Header/payload parser FSM with registered status pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         prev_valid_q <= 1'b1;
         cnt_q        <= 16'd0;
         len_q        <= 16'd0;
         seq_tmp_q    <= 16'd0;
         ssrc_q       <= 24'd0;
         hi_q         <= 8'd0;
         have_seq_q   <= 1'b0;
         last_seq_q   <= 16'd0;
         pkt_ok_q     <= 1'b0;
         pkt_drop_q   <= 1'b0;
         seq_gap_q    <= 1'b0;
      end else begin
         prev_valid_q <= valid_s;
         pkt_ok_q     <= 1'b0;
         pkt_drop_q   <= 1'b0;
         seq_gap_q    <= 1'b0;
         if (accept_s) begin
            pkt_ok_q   <= 1'b1;
            last_seq_q <= seq_tmp_q;
            seq_gap_q  <= have_seq_q & (seq_tmp_q != seq_next_s);
            have_seq_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (byte0_s) begin
                  len_q <= bus.udp_rec_data_length;
                  cnt_q <= 16'd1;
                  if (len_bad_s || (byte_s != RTP_HDR_B0)) begin
                     state_q    <= ST_DISCARD;
                     pkt_drop_q <= 1'b1;
                  end else begin
                     state_q <= ST_HDR;
                  end
               end
            end
            ST_HDR: begin
               if (!valid_s) begin
                  pkt_drop_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
                  case (cnt_q[3:0])
                     4'd1: begin
                        if (byte_s[6:0] != PT) begin
                           pkt_drop_q <= 1'b1;
                           state_q    <= ST_DISCARD;
                        end
                     end
                     4'd2:    seq_tmp_q[15:8] <= byte_s;
                     4'd3:    seq_tmp_q[7:0]  <= byte_s;
                     4'd8,
                     4'd9,
                     4'd10:   ssrc_q <= {ssrc_q[15:0], byte_s};
                     4'd11: begin
                        if (!ssrc_ok_s) begin
                           pkt_drop_q <= 1'b1;
                           state_q    <= ST_DISCARD;
                        end else if (accept_s) begin
                           state_q <= ST_DONE;
                        end else begin
                           state_q <= ST_PAYLOAD;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_PAYLOAD: begin
               if (!valid_s) begin
                  // Truncated: written samples stay, a dangling high byte is simply forgotten.
                  pkt_drop_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
                  if (!cnt_q[0]) begin
                     hi_q <= byte_s;
                  end
                  if (accept_s) begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Skip DISCARD when the run already ended so a new byte 0 next cycle is seen.
               if (valid_s) begin
                  state_q <= ST_DISCARD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DISCARD: begin
               if (!valid_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sample storage write port (contents need no reset; level/pointers define validity)
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= fifo_wdata_s;
      end
   end

   // FIFO pointers, level, priming and playback output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         level_q         <= '0;
         primed_q        <= 1'b0;
         wav_out_data_q  <= 16'd0;
         wav_out_valid_q <= 1'b0;
         overflow_q      <= 1'b0;
         underrun_q      <= 1'b0;
      end else begin
         overflow_q      <= fifo_wr_s & ~wr_ok_s;
         underrun_q      <= bus.wav_rden & primed_q & empty_s;
         wav_out_valid_q <= bus.wav_rden;
         if (wr_ok_s) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_ok_s, pop_s})
            2'b10:   level_q <= level_q + ONE_L;
            2'b01:   level_q <= level_q - ONE_L;
            default: level_q <= level_q;
         endcase
         if (bus.wav_rden && primed_q && empty_s) begin
            primed_q <= 1'b0;
         end else if (level_q >= PREFILL_L) begin
            primed_q <= 1'b1;
         end
         if (bus.wav_rden) begin
            wav_out_data_q <= pop_s ? mem_q[rd_ptr_q] : 16'd0;
         end
      end
   end

   assign bus.wav_out_data  = wav_out_data_q;
   assign bus.wav_out_valid = wav_out_valid_q;
   assign fifo_level        = level_q;
   assign pkt_ok            = pkt_ok_q;
   assign pkt_drop          = pkt_drop_q;
   assign seq_gap           = seq_gap_q;
   assign last_seq          = last_seq_q;
   assign overflow          = overflow_q;
   assign underrun          = underrun_q;

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Self-checking bench for rtp_rx_depacketizer: a default-sized instance (A)
// and a small-FIFO instance (B, AW=4, PREFILL=8) driven with directed and
// randomized packets against a queue-based reference model.
module tb_rtp_rx_depacketizer;
   typedef logic [7:0]  bq_t [$];
   typedef logic [15:0] sq_t [$];

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rtp_rx_depacketizer_if ifa ();
   rtp_rx_depacketizer_if ifb ();

   logic [10:0] lvl_a;
   logic [4:0]  lvl_b;
   logic        ok_a, drop_a, gap_a, ovf_a, und_a;
   logic        ok_b, drop_b, gap_b, ovf_b, und_b;
   logic [15:0] lseq_a, lseq_b;

   rtp_rx_depacketizer u_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .fifo_level(lvl_a),
      .pkt_ok(ok_a), .pkt_drop(drop_a), .seq_gap(gap_a), .last_seq(lseq_a),
      .overflow(ovf_a), .underrun(und_a)
   );

   rtp_rx_depacketizer #(.AW(4), .PREFILL(8)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .fifo_level(lvl_b),
      .pkt_ok(ok_b), .pkt_drop(drop_b), .seq_gap(gap_b), .last_seq(lseq_b),
      .overflow(ovf_b), .underrun(und_b)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_cyc = 0;
   int n_ok_a = 0, n_drop_a = 0, n_gap_a = 0, n_ovf_b = 0, n_ok_b = 0, n_drop_b = 0;
   int ok_cyc_a = -1, gap_cyc_a = -1;

   // reference model for instance A
   sq_t         exp_a;
   logic [15:0] m_last = 16'd0;
   logic        m_have = 1'b0;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (ok_a)   begin n_ok_a <= n_ok_a + 1; ok_cyc_a <= cyc; end
      if (drop_a) n_drop_a <= n_drop_a + 1;
      if (gap_a)  begin n_gap_a <= n_gap_a + 1; gap_cyc_a <= cyc; end
      if (ok_b)   n_ok_b <= n_ok_b + 1;
      if (drop_b) n_drop_b <= n_drop_b + 1;
      if (ovf_b)  n_ovf_b <= n_ovf_b + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic [15:0] l);
      if (sel == 0) begin
         ifa.udp_rec_data_valid = v; ifa.udp_rec_rdata = d; ifa.udp_rec_data_length = l;
      end else begin
         ifb.udp_rec_data_valid = v; ifb.udp_rec_rdata = d; ifb.udp_rec_data_length = l;
      end
   endtask

   task automatic build(input logic [7:0] b0, input logic [6:0] pt, input logic [15:0] seq,
                        input logic [31:0] ssrc, input sq_t s, output bq_t q);
      q = {};
      q.push_back(b0); q.push_back({1'b0, pt});
      q.push_back(seq[15:8]); q.push_back(seq[7:0]);
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h01);
      q.push_back(ssrc[31:24]); q.push_back(ssrc[23:16]); q.push_back(ssrc[15:8]); q.push_back(ssrc[7:0]);
      foreach (s[i]) begin
         q.push_back(s[i][15:8]);
         q.push_back(s[i][7:0]);
      end
   endtask

   task automatic send(input int sel, input bq_t q, input logic [15:0] len, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         set_in(sel, 1'b1, q[i], len);
         tick();
      end
      last_cyc = cyc;
      set_in(sel, 1'b0, 8'h00, 16'h0000);
      for (int i = 0; i < gap; i++) tick();
   endtask

   task automatic read(input int sel, output logic [15:0] d, output logic v, output logic u);
      if (sel == 0) ifa.wav_rden = 1'b1; else ifb.wav_rden = 1'b1;
      tick();
      ifa.wav_rden = 1'b0; ifb.wav_rden = 1'b0;
      d = (sel == 0) ? ifa.wav_out_data : ifb.wav_out_data;
      v = (sel == 0) ? ifa.wav_out_valid : ifb.wav_out_valid;
      u = (sel == 0) ? und_a : und_b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_in(0, 1'b0, 8'h00, 16'h0000);
      set_in(1, 1'b0, 8'h00, 16'h0000);
      ifa.wav_rden = 1'b0; ifb.wav_rden = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      exp_a = {}; m_last = 16'd0; m_have = 1'b0;
   endtask

   // sends one good packet on A, updates the model and checks ok/gap/last_seq/level
   task automatic good_pkt_a(input string nm, input logic [15:0] seq, input sq_t s);
      bq_t q; int ok0, gap0; logic exp_gap; logic [15:0] nx;
      ok0 = n_ok_a; gap0 = n_gap_a;
      nx = m_last + 16'd1;
      exp_gap = m_have && (seq != nx);
      build(8'h80, 7'd0, seq, 32'h12345678, s, q);
      send(0, q, 16'(q.size()), q.size(), 2);
      foreach (s[i]) exp_a.push_back(s[i]);
      m_last = seq; m_have = 1'b1;
      tests++;
      if (n_ok_a - ok0 !== 1 || n_gap_a - gap0 !== int'(exp_gap) || lseq_a !== seq ||
          int'(lvl_a) !== exp_a.size()) begin
         fails++;
         $display("FAIL %s: ok=%0d gap=%0d last_seq=%h level=%0d, expected ok=1 gap=%0d last_seq=%h level=%0d",
                  nm, n_ok_a - ok0, n_gap_a - gap0, lseq_a, lvl_a, exp_gap, seq, exp_a.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (lvl_a !== 11'd0 || ok_a !== 1'b0 || drop_a !== 1'b0 || lseq_a !== 16'd0 ||
          ifa.wav_out_valid !== 1'b0 || ifa.wav_out_data !== 16'd0 || und_a !== 1'b0) begin
         fails++;
         $display("FAIL reset_a: level=%0d ok=%b drop=%b last_seq=%h wv=%b wd=%h und=%b, expected all 0",
                  lvl_a, ok_a, drop_a, lseq_a, ifa.wav_out_valid, ifa.wav_out_data, und_a);
      end
      tests++;
      if (lvl_b !== 5'd0 || ovf_b !== 1'b0 || lseq_b !== 16'd0) begin
         fails++;
         $display("FAIL reset_b: level=%0d ovf=%b last_seq=%h, expected 0", lvl_b, ovf_b, lseq_b);
      end
   endtask

   task automatic test_valid_packet();
      sq_t s; logic [15:0] d; logic v, u; logic [15:0] e; int drop0;
      for (int i = 0; i < 474; i++) s.push_back(16'(i));
      drop0 = n_drop_a;
      good_pkt_a("valid_seq5", 16'd5, s);
      tests++;
      if (ok_cyc_a !== last_cyc || n_drop_a !== drop0) begin
         fails++;
         $display("FAIL valid_latency: pkt_ok cycle=%0d drops=%0d, expected cycle=%0d drops=0",
                  ok_cyc_a, n_drop_a - drop0, last_cyc);
      end
      good_pkt_a("valid_seq6", 16'd6, s);
      for (int i = 0; i < 948; i++) begin
         read(0, d, v, u);
         e = exp_a.pop_front();
         tests++;
         if (d !== e || v !== 1'b1 || u !== 1'b0) begin
            fails++;
            $display("FAIL drain_%0d: data=%h valid=%b und=%b, expected data=%h valid=1 und=0", i, d, v, u, e);
         end
      end
   endtask

   task automatic test_seq_gap();
      sq_t s;
      s = {};
      good_pkt_a("seq_5", 16'd5, s);
      good_pkt_a("seq_7", 16'd7, s);
      tests++;
      if (gap_cyc_a !== ok_cyc_a) begin
         fails++;
         $display("FAIL gap_align: seq_gap cycle=%0d, expected pkt_ok cycle=%0d", gap_cyc_a, ok_cyc_a);
      end
      good_pkt_a("seq_ffff", 16'hFFFF, s);
      good_pkt_a("seq_wrap0", 16'h0000, s);
   endtask

   task automatic test_rejects();
      sq_t s; bq_t q; int drop0, ok0; logic [15:0] len; int n;
      for (int k = 0; k < 4; k++) s.push_back(16'hA000 + 16'(k));
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: build(8'h90, 7'd0, m_last + 16'd1, 32'h12345678, s, q);
            1: build(8'h80, 7'd8, m_last + 16'd1, 32'h12345678, s, q);
            2: build(8'h80, 7'd0, m_last + 16'd1, 32'hDEADBEEF, s, q);
            default: build(8'h80, 7'd0, m_last + 16'd1, 32'h12345678, s, q);
         endcase
         len = 16'(q.size());
         if (c == 3) len = 16'd11;
         if (c == 4) len = 16'd13;
         n = int'(len);
         drop0 = n_drop_a; ok0 = n_ok_a;
         send(0, q, len, n, 2);
         tests++;
         if (n_drop_a - drop0 !== 1 || n_ok_a !== ok0 || int'(lvl_a) !== exp_a.size() || lseq_a !== m_last) begin
            fails++;
            $display("FAIL reject_%0d: drops=%0d oks=%0d level=%0d last_seq=%h, expected drops=1 oks=0 level=%0d last_seq=%h",
                     c, n_drop_a - drop0, n_ok_a - ok0, lvl_a, lseq_a, exp_a.size(), m_last);
         end
      end
   endtask

   task automatic test_truncation();
      sq_t s; sq_t s2; bq_t q; bq_t q2; int drop0, ok0; logic [15:0] d; logic v, u; logic [15:0] e;
      s = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      s2 = '{16'h5555, 16'h6666, 16'h7777};
      build(8'h80, 7'd0, m_last + 16'd1, 32'h12345678, s, q);
      build(8'h80, 7'd0, m_last + 16'd1, 32'h12345678, s2, q2);
      drop0 = n_drop_a; ok0 = n_ok_a;
      send(0, q, 16'd20, 16, 1);
      send(0, q2, 16'd18, 18, 2);
      exp_a.push_back(16'h1111); exp_a.push_back(16'h2222);
      foreach (s2[i]) exp_a.push_back(s2[i]);
      m_last = m_last + 16'd1;
      tests++;
      if (n_drop_a - drop0 !== 1 || n_ok_a - ok0 !== 1 || int'(lvl_a) !== 5 || lseq_a !== m_last) begin
         fails++;
         $display("FAIL truncation: drops=%0d oks=%0d level=%0d last_seq=%h, expected drops=1 oks=1 level=5 last_seq=%h",
                  n_drop_a - drop0, n_ok_a - ok0, lvl_a, lseq_a, m_last);
      end
      for (int i = 0; i < 5; i++) begin
         read(0, d, v, u);
         e = exp_a.pop_front();
         tests++;
         if (d !== e || v !== 1'b1) begin
            fails++;
            $display("FAIL trunc_drain_%0d: data=%h valid=%b, expected %h valid=1", i, d, v, e);
         end
      end
      read(0, d, v, u);
      tests++;
      if (d !== 16'd0 || v !== 1'b1 || u !== 1'b1) begin
         fails++;
         $display("FAIL underrun_a: data=%h valid=%b und=%b, expected 0 1 1", d, v, u);
      end
   endtask

   task automatic test_underrun_overflow();
      sq_t s; bq_t q; logic [15:0] d; logic v, u; int ovf0, ok0;
      read(1, d, v, u);
      tests++;
      if (d !== 16'd0 || v !== 1'b1 || u !== 1'b0 || lvl_b !== 5'd0) begin
         fails++;
         $display("FAIL unprimed_b: data=%h valid=%b und=%b level=%0d, expected 0 1 0 0", d, v, u, lvl_b);
      end
      for (int i = 0; i < 8; i++) s.push_back(16'hB000 + 16'(i));
      build(8'h80, 7'd0, 16'd1, 32'h12345678, s, q);
      send(1, q, 16'd28, 28, 2);
      for (int i = 0; i < 9; i++) begin
         read(1, d, v, u);
         tests++;
         if (i < 8) begin
            if (d !== s[i] || v !== 1'b1 || u !== 1'b0) begin
               fails++;
               $display("FAIL b_read_%0d: data=%h valid=%b und=%b, expected %h 1 0", i, d, v, u, s[i]);
            end
         end else begin
            if (d !== 16'd0 || v !== 1'b1 || u !== 1'b1) begin
               fails++;
               $display("FAIL b_underrun: data=%h valid=%b und=%b, expected 0 1 1", d, v, u);
            end
         end
      end
      read(1, d, v, u);
      tests++;
      if (d !== 16'd0 || v !== 1'b1 || u !== 1'b0) begin
         fails++;
         $display("FAIL b_after_underrun: data=%h valid=%b und=%b, expected 0 1 0", d, v, u);
      end
      s = {};
      for (int i = 0; i < 20; i++) s.push_back(16'(i));
      build(8'h80, 7'd0, 16'd2, 32'h12345678, s, q);
      ovf0 = n_ovf_b; ok0 = n_ok_b;
      send(1, q, 16'd52, 52, 2);
      tests++;
      if (n_ovf_b - ovf0 !== 4 || lvl_b !== 5'd16 || n_ok_b - ok0 !== 1) begin
         fails++;
         $display("FAIL b_overflow: overflows=%0d level=%0d oks=%0d, expected 4 16 1",
                  n_ovf_b - ovf0, lvl_b, n_ok_b - ok0);
      end
   endtask

   task automatic test_reset_mid_packet();
      sq_t s; bq_t q; int ok0, drop0;
      for (int i = 0; i < 100; i++) s.push_back(16'hC000 + 16'(i));
      build(8'h80, 7'd0, 16'd40, 32'h12345678, s, q);
      for (int i = 0; i < q.size(); i++) begin
         if (i == 112) rst_n = 1'b0;
         if (i == 115) begin
            rst_n = 1'b1;
            ok0 = n_ok_a; drop0 = n_drop_a;
         end
         set_in(0, 1'b1, q[i], 16'(q.size()));
         tick();
      end
      set_in(0, 1'b0, 8'h00, 16'h0000);
      tick(); tick();
      exp_a = {}; m_last = 16'd0; m_have = 1'b0;
      tests++;
      if (n_ok_a !== ok0 || n_drop_a !== drop0 || lvl_a !== 11'd0 || lseq_a !== 16'd0) begin
         fails++;
         $display("FAIL reset_mid: oks=%0d drops=%0d level=%0d last_seq=%h, expected 0 0 0 0",
                  n_ok_a - ok0, n_drop_a - drop0, lvl_a, lseq_a);
      end
      s = {};
      for (int i = 0; i < 10; i++) s.push_back(16'hD000 + 16'(i));
      good_pkt_a("after_reset", 16'd77, s);
   endtask

   task automatic test_random();
      sq_t s; bq_t q; int kind, ns, k, ok0, drop0, gap0, pk;
      logic [15:0] seq, d, e, nx; logic v, u, eg;
      do_reset();
      pk = 0;
      while (exp_a.size() < 512 && pk < 200) begin
         pk++;
         kind = $urandom_range(0, 5);
         ns = $urandom_range(0, 40);
         if (kind == 5 && ns == 0) ns = 1;
         s = {};
         for (int i = 0; i < ns; i++) s.push_back(16'($urandom));
         nx = m_last + 16'd1;
         seq = ($urandom_range(0, 1) == 0) ? nx : 16'($urandom);
         build((kind == 3) ? 8'h81 : 8'h80, (kind == 4) ? 7'd3 : 7'd0, seq, 32'h12345678, s, q);
         ok0 = n_ok_a; drop0 = n_drop_a; gap0 = n_gap_a;
         eg = 1'b0;
         if (kind == 5) begin
            k = $urandom_range(1, q.size() - 1);
            send(0, q, 16'(q.size()), k, $urandom_range(2, 3));
            for (int i = 0; i < (k - 12) / 2; i++) exp_a.push_back(s[i]);
         end else begin
            send(0, q, 16'(q.size()), q.size(), $urandom_range(2, 3));
            if (kind < 3) begin
               eg = m_have && (seq != nx);
               foreach (s[i]) exp_a.push_back(s[i]);
               m_last = seq; m_have = 1'b1;
            end
         end
         tests++;
         if (n_ok_a - ok0 !== int'(kind < 3) || n_drop_a - drop0 !== int'(kind >= 3) ||
             n_gap_a - gap0 !== int'(eg) || int'(lvl_a) !== exp_a.size() || lseq_a !== m_last) begin
            fails++;
            $display("FAIL rand_pkt_%0d kind=%0d: ok=%0d drop=%0d gap=%0d level=%0d last_seq=%h, expected ok=%0d drop=%0d gap=%0d level=%0d last_seq=%h",
                     pk, kind, n_ok_a - ok0, n_drop_a - drop0, n_gap_a - gap0, lvl_a, lseq_a,
                     int'(kind < 3), int'(kind >= 3), eg, exp_a.size(), m_last);
         end
      end
      tests++;
      if (exp_a.size() < 512) begin
         fails++;
         $display("FAIL rand_prefill: model level=%0d, required >= 512", exp_a.size());
      end else begin
         while (exp_a.size() > 0) begin
            read(0, d, v, u);
            e = exp_a.pop_front();
            tests++;
            if (d !== e || v !== 1'b1) begin
               fails++;
               $display("FAIL rand_drain: data=%h valid=%b, expected %h valid=1", d, v, e);
            end
         end
         read(0, d, v, u);
         tests++;
         if (d !== 16'd0 || u !== 1'b1) begin
            fails++;
            $display("FAIL rand_underrun: data=%h und=%b, expected 0 1", d, u);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 1'b0, 8'h00, 16'h0000);
      set_in(1, 1'b0, 8'h00, 16'h0000);
      ifa.wav_rden = 1'b0; ifb.wav_rden = 1'b0;
      test_reset();
      test_valid_packet();
      test_seq_gap();
      test_rejects();
      test_truncation();
      test_underrun_overflow();
      test_reset_mid_packet();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rtp_rx_depacketizer.md
Name: rtp_rx_depacketizer

Overview:
- Receive-side counterpart of the RTP audio packetizer. It consumes the UDP receive byte stream (udp_rec_*), validates the 12-byte RTP header and unpacks big-endian 16-bit PCM samples into a sample FIFO.
- The WM8731 playback path drains the FIFO one sample per codec strobe.
- It also provides prefill/underrun handling and sequence-gap detection.

Parameters:
- RTP_HDR_B0, 8'h80, required byte 0 (V=2, P=0, X=0, CC=0).
- PT, 7'd0, required payload type (byte 1 bits [6:0]; marker bit ignored).
- SSRC, 32'h12345678, expected SSRC.
- CHECK_SSRC, 1, 1 = drop packets whose SSRC differs from SSRC.
- AW, 10, FIFO address width; depth = 2^AW samples.
- PREFILL, 512, FIFO level required before playback starts or restarts (1..2^AW).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- udp_rec_data_valid  in  1  byte strobe; one contiguous high run = one packet
- udp_rec_rdata  in  8  received UDP payload byte
- udp_rec_data_length  in  16  UDP payload length in bytes; sampled on byte 0
- wav_rden  in  1  single-cycle sample request from the codec side
- wav_out_data  out  16  signed sample, big-endian reassembled
- wav_out_valid  out  1  pulse, one cycle after each wav_rden
- fifo_level  out  AW+1  samples currently stored
- pkt_ok  out  1  pulse: a packet was fully accepted
- pkt_drop  out  1  pulse: a packet was rejected or truncated
- seq_gap  out  1  pulse with pkt_ok when seq != last_seq+1
- last_seq  out  16  sequence number of the last accepted packet
- overflow  out  1  pulse: a sample was lost because the FIFO was full
- underrun  out  1  pulse: wav_rden arrived while primed with the FIFO empty

Behaviour:
- Reset values: all outputs 0, FIFO empty, primed=0, have_seq=0, state IDLE.
- The prev_valid register resets to 1, so a packet already in flight at reset is ignored until valid goes low.
- Byte 0 is defined as valid=1 with prev_valid=0. The byte counter starts at 0 and the length is latched on byte 0.
- State IDLE, on byte 0:
  - If length < 12 or (length-12) is odd -> DISCARD and pulse pkt_drop.
  - Else if byte != RTP_HDR_B0 -> DISCARD and pulse pkt_drop.
  - Else -> HDR.
- State HDR (bytes 1..11):
  - Byte 1: [6:0] != PT -> DISCARD and pulse pkt_drop.
  - Bytes 2-3: sequence number, MSB first, captured into seq_tmp.
  - Bytes 4-7: timestamp, ignored.
  - Bytes 8-11: SSRC, compared after byte 11. A mismatch with CHECK_SSRC=1 -> DISCARD and pulse pkt_drop.
  - Byte 11 with length == 12 -> DONE (empty payload is legal).
  - Otherwise byte 11 -> PAYLOAD.
- State PAYLOAD:
  - Even payload byte latches hi.
  - Odd payload byte writes {hi, byte} to the FIFO in the same cycle.
  - If the FIFO is full, the sample is discarded and overflow pulses; parsing continues.
  - The last byte (counter == length-1) -> DONE.
- State DONE (one cycle):
  - pkt_ok pulses; last_seq <= seq_tmp.
  - seq_gap pulses if have_seq=1 and seq_tmp != last_seq+1 (mod 2^16).
  - have_seq <= 1; then -> DISCARD.
- State DISCARD: ignores bytes, and returns to IDLE in the cycle valid is low.
  - Bytes beyond length in the same run are ignored silently; pkt_ok still stands.
- Truncation: valid falls in HDR or PAYLOAD before length is reached.
  - pkt_drop pulses; state -> IDLE.
  - Samples already written stay in the FIFO; last_seq is not updated.
  - A dangling odd byte is dropped.
- Byte 0 of a new packet may arrive the cycle after valid falls.
- Playback and priming:
  - primed sets when fifo_level >= PREFILL.
  - While unprimed, wav_rden returns 0 with wav_out_valid, pops nothing, and does not pulse underrun.
  - While primed and not empty, wav_rden pops the head sample; wav_out_data and wav_out_valid appear the next cycle (latency 1).
  - While primed and empty, wav_rden gives wav_out_data=0, wav_out_valid=1, pulses underrun, and clears primed.
  - wav_out_data holds its value between reads.
- Simultaneous FIFO write and pop: both occur; fifo_level is unchanged.
  - Full plus pop plus write: the write succeeds with no overflow, because the pop is evaluated first.
- Pointers wrap modulo 2^AW; fifo_level ranges 0..2^AW.
- A mid-operation reset clears the FIFO, the flags and last_seq.

Test Plan:
- Valid packet: 960 bytes, hdr 80 00 00 05 00000001 12345678, payload 474 samples 0x0000..0x01D9.
  - Expect pkt_ok=1 one cycle after the last byte, pkt_drop=0, last_seq=5, fifo_level=474.
  - Then send a second identical packet with seq 6 -> level 948 and primed.
  - 948 rden pulses -> data 0x0000..0x01D9 twice, in order.
- Sequence gap: accepted seq 5, then seq 7 -> pkt_ok and seq_gap pulse together, last_seq=7.
  - seq 0xFFFF followed by 0x0000 -> no seq_gap.
- Rejects, each leaving fifo_level unchanged and pulsing pkt_drop once:
  - byte0=0x90;
  - PT=8;
  - SSRC 0xDEADBEEF;
  - length 11;
  - length 13.
- Truncation: length 20 declared but valid dropped after byte 15 -> pkt_drop, fifo_level +2 (two samples), last_seq unchanged.
  - A back-to-back packet starting the next cycle is parsed normally.
- Underrun and overflow:
  - With AW=4 and PREFILL=8, write 8 samples, then issue 9 rden -> 8 samples out, 9th returns 0 with underrun=1.
  - A following rden returns 0 with no underrun (unprimed).
  - Write 20 samples -> overflow pulses 4 times and fifo_level=16.
- Reset mid-packet: assert rst_n=0 at payload byte 100, release it while valid is still high.
  - Expect the remainder ignored, no pkt_ok or pkt_drop, fifo_level=0.
  - The next packet is accepted.
